// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage hazard unit: load-use and write-decode stalls
//               plus a busy scoreboard for variable-latency long operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int NUM_REGS        = 32,
   parameter int REG_W           = 5,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3,
   parameter int RF_BYPASS       = 0,
   parameter int STORE_DATA_FWD  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                d_valid,
   input  logic [REG_W-1:0]    d_rs1,
   input  logic [REG_W-1:0]    d_rs2,
   input  logic                d_use_rs1,
   input  logic                d_use_rs2,
   input  logic                d_is_store,
   input  logic                d_is_long,
   input  logic [REG_W-1:0]    d_rd,
   input  logic                x_valid,
   input  logic [REG_W-1:0]    x_rd,
   input  logic                x_is_load,
   input  logic                x_is_long,
   input  logic                x_is_jump,
   input  logic                branch_taken,
   input  logic                w_valid,
   input  logic                w_we,
   input  logic [REG_W-1:0]    w_rd,
   input  logic                cpl_valid,
   input  logic [REG_W-1:0]    cpl_rd,
   output logic                stall,
   output logic                stall_load_use,
   output logic                stall_wd,
   output logic                stall_busy,
   output logic                stall_full,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    outstanding,
   output logic                err_cpl
);

   localparam logic [CNT_W:0]   C_MAX_EXT = (CNT_W+1)'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic             C_WD_EN   = (RF_BYPASS == 0);
   localparam logic             C_SD_FWD  = (STORE_DATA_FWD != 0);

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;

   logic w_issue, w_flush, w_cpl_legal;
   logic w_rs1_act, w_rs2_act;
   logic w_rs1_raw, w_rs2_raw, w_waw;
   logic w_load_use, w_wd, w_busy_hit, w_full;
   logic [CNT_W:0] w_cnt_proj;

   assign w_issue     = x_valid & x_is_long;
   assign w_flush     = branch_taken | x_is_jump;
   assign w_cpl_legal = cpl_valid & (r_cnt != '0);

   assign w_rs1_act = d_use_rs1 & (d_rs1 != '0);
   assign w_rs2_act = d_use_rs2 & (d_rs2 != '0);

   assign w_load_use = d_valid & x_valid & x_is_load & (x_rd != '0) &
                       ((w_rs1_act & (d_rs1 == x_rd)) |
                        (w_rs2_act & (d_rs2 == x_rd) & ~(C_SD_FWD & d_is_store)));

   assign w_wd = d_valid & C_WD_EN & w_valid & w_we &
                 ((w_rs1_act & (d_rs1 == w_rd)) | (w_rs2_act & (d_rs2 == w_rd)));

   // A completion arriving this cycle releases its register in time for D.
   assign w_rs1_raw = w_rs1_act &
                      ((r_busy[d_rs1] & ~(cpl_valid & (cpl_rd == d_rs1))) |
                       (w_issue & (x_rd != '0) & (x_rd == d_rs1)));
   assign w_rs2_raw = w_rs2_act &
                      ((r_busy[d_rs2] & ~(cpl_valid & (cpl_rd == d_rs2))) |
                       (w_issue & (x_rd != '0) & (x_rd == d_rs2)));
   assign w_waw     = d_is_long & (r_busy[d_rd] | (w_issue & (d_rd == x_rd)));

   assign w_busy_hit = d_valid & (w_rs1_raw | w_rs2_raw | w_waw);

   assign w_cnt_proj = ({1'b0, r_cnt} + (CNT_W+1)'(w_issue)) - (CNT_W+1)'(w_cpl_legal);
   assign w_full     = d_valid & d_is_long & (w_cnt_proj >= C_MAX_EXT);

   always_comb begin
      stall_load_use = 1'b0;
      stall_wd       = 1'b0;
      stall_busy     = 1'b0;
      stall_full     = 1'b0;
      if (!w_flush) begin
         stall_load_use = w_load_use;
         stall_wd       = w_wd;
         stall_busy     = w_busy_hit;
         stall_full     = w_full;
      end
      stall = stall_load_use | stall_wd | stall_busy | stall_full;
   end

   // Clear then set, so a same-index issue and completion leaves the bit set.
   always_comb begin
      w_busy_next = r_busy;
      if (cpl_valid)
         w_busy_next[cpl_rd] = 1'b0;
      if (w_issue && (x_rd != '0))
         w_busy_next[x_rd] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         if (w_issue && !w_cpl_legal) begin
            if (r_cnt != C_MAX_CNT)
               r_cnt <= r_cnt + 1'b1;
         end else if (!w_issue && w_cpl_legal) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if ((cpl_valid && (r_cnt == '0)) ||
             (cpl_valid && (cpl_rd != '0) && !r_busy[cpl_rd]) ||
             (w_issue && !w_cpl_legal && (r_cnt == C_MAX_CNT)))
            r_err <= 1'b1;
      end
   end

   assign busy_vec    = r_busy;
   assign outstanding = r_cnt;
   assign err_cpl     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Two differently configured hazard_scoreboard instances driven
//               by shared stimulus and compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] d_rs1, d_rs2, d_rd, x_rd, w_rd, cpl_rd;
   logic d_valid, d_use_rs1, d_use_rs2, d_is_store, d_is_long;
   logic x_valid, x_is_load, x_is_long, x_is_jump, branch_taken;
   logic w_valid, w_we, cpl_valid;

   logic        st [2];
   logic        lu [2];
   logic        wd [2];
   logic        bz [2];
   logic        fl [2];
   logic [31:0] bv [2];
   logic        er [2];
   logic [2:0]  oc0;
   logic [1:0]  oc1;

   hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .MAX_OUTSTANDING(4), .CNT_W(3),
                       .RF_BYPASS(0), .STORE_DATA_FWD(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_is_store(d_is_store),
      .d_is_long(d_is_long), .d_rd(d_rd), .x_valid(x_valid), .x_rd(x_rd),
      .x_is_load(x_is_load), .x_is_long(x_is_long), .x_is_jump(x_is_jump),
      .branch_taken(branch_taken), .w_valid(w_valid), .w_we(w_we), .w_rd(w_rd),
      .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .stall(st[0]), .stall_load_use(lu[0]),
      .stall_wd(wd[0]), .stall_busy(bz[0]), .stall_full(fl[0]), .busy_vec(bv[0]),
      .outstanding(oc0), .err_cpl(er[0]));

   hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .MAX_OUTSTANDING(2), .CNT_W(2),
                       .RF_BYPASS(1), .STORE_DATA_FWD(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_is_store(d_is_store),
      .d_is_long(d_is_long), .d_rd(d_rd), .x_valid(x_valid), .x_rd(x_rd),
      .x_is_load(x_is_load), .x_is_long(x_is_long), .x_is_jump(x_is_jump),
      .branch_taken(branch_taken), .w_valid(w_valid), .w_we(w_we), .w_rd(w_rd),
      .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .stall(st[1]), .stall_load_use(lu[1]),
      .stall_wd(wd[1]), .stall_busy(bz[1]), .stall_full(fl[1]), .busy_vec(bv[1]),
      .outstanding(oc1), .err_cpl(er[1]));

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state, one slot per instance
   bit [31:0] m_busy [2];
   int        m_cnt  [2];
   bit        m_err  [2];
   int        maxo   [2] = '{4, 2};
   bit        rfb    [2] = '{1'b0, 1'b1};
   bit        sfwd   [2] = '{1'b1, 1'b0};

   function automatic bit rs1_hit(input logic [4:0] r);
      return d_use_rs1 && d_rs1 == r && r != 0;
   endfunction

   function automatic bit rs2_hit(input logic [4:0] r);
      return d_use_rs2 && d_rs2 == r && r != 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = '0;
         m_cnt[k]  = 0;
         m_err[k]  = 1'b0;
      end
   endtask

   task automatic model_comb(input int k, output bit e_lu, output bit e_wd,
                             output bit e_bz, output bit e_fl);
      bit iss, leg;
      iss  = x_valid && x_is_long;
      leg  = cpl_valid && m_cnt[k] != 0;
      e_lu = d_valid && x_valid && x_is_load && x_rd != 0 &&
             (rs1_hit(x_rd) || (rs2_hit(x_rd) && !(sfwd[k] && d_is_store)));
      e_wd = d_valid && !rfb[k] && w_valid && w_we && (rs1_hit(w_rd) || rs2_hit(w_rd));
      e_bz = 1'b0;
      for (int r = 1; r < 32; r++) begin
         if (rs1_hit(5'(r)) || rs2_hit(5'(r))) begin
            if (m_busy[k][r] && !(cpl_valid && cpl_rd == 5'(r))) e_bz = 1'b1;
            if (iss && x_rd == 5'(r)) e_bz = 1'b1;
         end
      end
      if (d_is_long && (m_busy[k][d_rd] || (iss && d_rd == x_rd))) e_bz = 1'b1;
      e_bz = e_bz && d_valid;
      e_fl = d_valid && d_is_long && (m_cnt[k] + int'(iss) - int'(leg) >= maxo[k]);
      if (branch_taken || x_is_jump) begin
         e_lu = 1'b0; e_wd = 1'b0; e_bz = 1'b0; e_fl = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit iss, leg;
         iss = x_valid && x_is_long;
         leg = cpl_valid && m_cnt[k] != 0;
         if (cpl_valid) begin
            if (m_cnt[k] == 0) m_err[k] = 1'b1;
            if (cpl_rd != 0 && !m_busy[k][cpl_rd]) m_err[k] = 1'b1;
            m_busy[k][cpl_rd] = 1'b0;
         end
         if (iss && x_rd != 0) m_busy[k][x_rd] = 1'b1;
         if (iss && !leg) begin
            if (m_cnt[k] == maxo[k]) m_err[k] = 1'b1;
            else m_cnt[k]++;
         end else if (!iss && leg) begin
            m_cnt[k]--;
         end
      end
   endtask

   task automatic check_comb();
      for (int k = 0; k < 2; k++) begin
         bit e_lu, e_wd, e_bz, e_fl;
         model_comb(k, e_lu, e_wd, e_bz, e_fl);
         check_eq($sformatf("d%0d_lu", k), 32'(lu[k]), 32'(e_lu));
         check_eq($sformatf("d%0d_wd", k), 32'(wd[k]), 32'(e_wd));
         check_eq($sformatf("d%0d_busy_stall", k), 32'(bz[k]), 32'(e_bz));
         check_eq($sformatf("d%0d_full", k), 32'(fl[k]), 32'(e_fl));
         check_eq($sformatf("d%0d_stall", k), 32'(st[k]), 32'(e_lu | e_wd | e_bz | e_fl));
      end
   endtask

   task automatic check_state();
      check_eq("d0_busy_vec", bv[0], m_busy[0]);
      check_eq("d1_busy_vec", bv[1], m_busy[1]);
      check_eq("d0_outstanding", 32'(oc0), 32'(m_cnt[0]));
      check_eq("d1_outstanding", 32'(oc1), 32'(m_cnt[1]));
      check_eq("d0_err", 32'(er[0]), 32'(m_err[0]));
      check_eq("d1_err", 32'(er[1]), 32'(m_err[1]));
   endtask

   // Inputs are set just after a falling edge; this checks, clocks, re-checks.
   task automatic cycle();
      #1;
      check_comb();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_state();
   endtask

   task automatic idle();
      d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
      d_is_store = 0; d_is_long = 0; d_rd = 0;
      x_valid = 0; x_rd = 0; x_is_load = 0; x_is_long = 0; x_is_jump = 0;
      branch_taken = 0; w_valid = 0; w_we = 0; w_rd = 0; cpl_valid = 0; cpl_rd = 0;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      idle();
      x_valid = 1; x_is_long = 1; x_rd = rd;
      cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic randomize_inputs();
      int pick;
      d_valid    = ($urandom_range(0, 3) != 0);
      d_rs1      = 5'($urandom_range(0, 7));
      d_rs2      = 5'($urandom_range(0, 7));
      d_rd       = 5'($urandom_range(0, 7));
      d_use_rs1  = 1'($urandom_range(0, 1));
      d_use_rs2  = 1'($urandom_range(0, 1));
      d_is_store = ($urandom_range(0, 3) == 0);
      d_is_long  = ($urandom_range(0, 2) == 0);
      x_valid    = ($urandom_range(0, 3) != 0);
      pick       = int'($urandom_range(0, 3));
      x_is_load  = (pick == 0);
      x_is_long  = (pick == 1);
      x_rd       = 5'($urandom_range(0, 7));
      x_is_jump  = ($urandom_range(0, 11) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      w_valid    = 1'($urandom_range(0, 1));
      w_we       = 1'($urandom_range(0, 1));
      w_rd       = 5'($urandom_range(0, 7));
      cpl_valid  = 1'b0;
      cpl_rd     = 5'($urandom_range(0, 7));
      if (m_cnt[0] > 0 && $urandom_range(0, 2) == 0) begin
         int start;
         cpl_valid = 1'b1;
         cpl_rd    = 5'd0;
         start     = int'($urandom_range(0, 31));
         for (int j = 0; j < 32; j++) begin
            if (m_busy[0][(start + j) % 32] && cpl_rd == 5'd0)
               cpl_rd = 5'((start + j) % 32);
         end
      end else if ($urandom_range(0, 49) == 0) begin
         cpl_valid = 1'b1;
      end
   endtask

   initial begin
      idle();
      model_reset();
      @(negedge clk);
      #1;
      check_state();
      check_comb();
      rst_n = 1'b1;
      @(negedge clk);

      // load-use on rs1
      idle(); d_valid = 1; d_use_rs1 = 1; d_rs1 = 5; x_valid = 1; x_is_load = 1; x_rd = 5;
      #1;
      check_eq("lu_rs1", 32'(lu[0]), 1);
      check_eq("lu_rs1_stall", 32'(st[0]), 1);
      cycle();
      // store data operand: exempt only where store forwarding exists
      idle(); d_valid = 1; d_is_store = 1; d_use_rs1 = 1; d_rs1 = 2;
      d_use_rs2 = 1; d_rs2 = 5; x_valid = 1; x_is_load = 1; x_rd = 5;
      #1;
      check_eq("store_fwd_stall", 32'(st[0]), 0);
      check_eq("store_nofwd_stall", 32'(st[1]), 1);
      cycle();
      // load to x0
      idle(); d_valid = 1; d_use_rs1 = 1; d_rs1 = 0; x_valid = 1; x_is_load = 1; x_rd = 0;
      #1;
      check_eq("lu_x0", 32'(st[0]), 0);
      cycle();
      // write-decode
      idle(); d_valid = 1; d_use_rs2 = 1; d_rs2 = 7; w_valid = 1; w_we = 1; w_rd = 7;
      #1;
      check_eq("wd_hit", 32'(wd[0]), 1);
      check_eq("wd_bypass", 32'(wd[1]), 0);
      cycle();
      w_we = 0;
      #1;
      check_eq("wd_no_we", 32'(wd[0]), 0);
      cycle();
      // scoreboard RAW against a long op on x9
      issue_long(5'd9);
      idle(); d_valid = 1; d_use_rs1 = 1; d_rs1 = 9;
      #1;
      check_eq("sb_busy9", 32'(bv[0][9]), 1);
      check_eq("sb_cnt1", 32'(oc0), 1);
      check_eq("sb_raw", 32'(bz[0]), 1);
      cycle();
      cpl_valid = 1; cpl_rd = 9;
      #1;
      check_eq("sb_cpl_release", 32'(st[0]), 0);
      cycle();
      idle();
      #1;
      check_eq("sb_busy9_clr", 32'(bv[0][9]), 0);
      check_eq("sb_cnt0", 32'(oc0), 0);
      // outstanding limit on the two-deep instance
      issue_long(5'd3);
      issue_long(5'd4);
      idle(); d_valid = 1; d_is_long = 1; d_rd = 6;
      #1;
      check_eq("full_max2", 32'(fl[1]), 1);
      check_eq("full_max4", 32'(fl[0]), 0);
      cycle();
      cpl_valid = 1; cpl_rd = 3;
      #1;
      check_eq("full_cpl", 32'(fl[1]), 0);
      cycle();
      // taken branch suppresses a load-use hit
      idle(); d_valid = 1; d_use_rs1 = 1; d_rs1 = 5; x_valid = 1; x_is_load = 1; x_rd = 5;
      branch_taken = 1;
      #1;
      check_eq("flush_stall", 32'(st[0]), 0);
      cycle();
      // issue and completion of x4 together
      idle(); x_valid = 1; x_is_long = 1; x_rd = 4; cpl_valid = 1; cpl_rd = 4;
      cycle();
      idle();
      #1;
      check_eq("same_idx_busy4", 32'(bv[0][4]), 1);
      check_eq("same_idx_cnt", 32'(oc0), 1);
      cpl_valid = 1; cpl_rd = 4;
      cycle();
      // completion with nothing outstanding
      idle(); cpl_valid = 1; cpl_rd = 0;
      cycle();
      idle();
      #1;
      check_eq("err_set", 32'(er[0]), 1);
      cycle();
      check_eq("err_sticky", 32'(er[0]), 1);
      // asynchronous reset with live scoreboard state
      issue_long(5'd4);
      issue_long(5'd9);
      idle();
      #1;
      check_eq("pre_rst_busy", bv[0], 32'h0000_0210);
      check_eq("pre_rst_cnt", 32'(oc0), 2);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_busy", bv[0], 0);
      check_eq("async_rst_cnt", 32'(oc0), 0);
      check_eq("async_rst_err", 32'(er[0]), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 800; i++) begin
         if (i % 80 == 79) do_reset();
         randomize_inputs();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
